emotion_sequencer: RTL and testbench

Sequencer that owns the three 2-bit mood levels (energy, stress, pleasure) feeding `emotional_model` and registers its 8-bit emotion result. It accepts stimulus events over a valid/ready handshake and applies a periodic decay tick, giving the decay priority when both arrive together. It samples the classifier after every level change and commits a new emotion subject to a minimum hold time, so the visible emotion does not flicker.

---
 rtl/emotion_sequencer.sv | 178 +++++++++++++++++
 tb/tb_emotion_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/emotion_sequencer.sv
// emotion_sequencer: owns the energy/stress/pleasure levels, applies stimuli and periodic decay, commits the classifier result with a minimum hold.
// Latency: accept/decay at E0 updates levels at E0; emotion_out and the one-cycle emotion_update pulse appear at E0+2.
// Backpressure: stim_ready is low outside IDLE, while a decay is pending, or while an expired-hold re-evaluation is owed.
module emotion_sequencer #(
    parameter int TICK_DIV   = 1000,
    parameter int HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stim_valid,
    input  logic [1:0] stim_code,
    output logic       stim_ready,
    output logic [1:0] energy,
    output logic [1:0] stress,
    output logic [1:0] pleasure,
    input  logic [7:0] emotion_in,
    output logic [7:0] emotion_out,
    output logic       emotion_update,
    output logic       busy
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam int              HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_TICKS);

    localparam logic [1:0] CODE_FEED  = 2'd0;
    localparam logic [1:0] CODE_PLAY  = 2'd1;
    localparam logic [1:0] CODE_SCOLD = 2'd2;
    localparam logic [1:0] CODE_REST  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      energy_q, energy_d;
    logic [1:0]      stress_q, stress_d;
    logic [1:0]      pleasure_q, pleasure_d;
    logic [7:0]      emotion_out_q, emotion_out_d;
    logic            emotion_update_q, emotion_update_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            decay_pending_q, decay_pending_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            change_pending_q, change_pending_d;

    logic            wrap;
    logic            re_eval;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

    // A held change whose hold has expired must be re-evaluated before any new stimulus.
    assign wrap       = (presc_q == PRESC_MAX);
    assign re_eval    = change_pending_q && (hold_cnt_q == '0);
    assign stim_ready = (state_q == ST_IDLE) && !decay_pending_q && !re_eval;

    assign energy         = energy_q;
    assign stress         = stress_q;
    assign pleasure       = pleasure_q;
    assign emotion_out    = emotion_out_q;
    assign emotion_update = emotion_update_q;
    assign busy           = (state_q != ST_IDLE);

    // Next-state logic: prescaler/tick bookkeeping, then the IDLE->SETTLE->EVAL sequence.
    always_comb begin
        state_d          = state_q;
        energy_d         = energy_q;
        stress_d         = stress_q;
        pleasure_d       = pleasure_q;
        emotion_out_d    = emotion_out_q;
        emotion_update_d = 1'b0;
        presc_d          = wrap ? '0 : presc_q + PW'(1);
        decay_pending_d  = decay_pending_q;
        hold_cnt_d       = hold_cnt_q;
        change_pending_d = change_pending_q;

        // A tick arriving while one is still pending is dropped, not queued.
        if (wrap && !decay_pending_q) begin
            decay_pending_d = 1'b1;
        end
        if (wrap && (hold_cnt_q != '0)) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (decay_pending_q) begin
                    decay_pending_d = 1'b0;
                    if (energy_q == 2'd0) begin
                        stress_d = sat_inc(stress_q);
                    end else begin
                        energy_d = energy_q - 2'd1;
                    end
                    state_d = ST_SETTLE;
                end else if (re_eval) begin
                    state_d = ST_SETTLE;
                end else if (stim_valid) begin
                    case (stim_code)
                        CODE_FEED: begin
                            energy_d   = sat_inc(energy_q);
                            pleasure_d = sat_inc(pleasure_q);
                        end
                        CODE_PLAY: begin
                            pleasure_d = sat_inc(pleasure_q);
                            energy_d   = sat_dec(energy_q);
                        end
                        CODE_SCOLD: begin
                            stress_d   = sat_inc(stress_q);
                            pleasure_d = sat_dec(pleasure_q);
                        end
                        CODE_REST: begin
                            energy_d   = sat_inc(energy_q);
                            stress_d   = sat_dec(stress_q);
                        end
                        default: ;
                    endcase
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = ST_IDLE;
                if (emotion_in == emotion_out_q) begin
                    change_pending_d = 1'b0;
                end else if (hold_cnt_q == '0) begin
                    // Reload overrides any same-edge tick decrement.
                    emotion_out_d    = emotion_in;
                    emotion_update_d = 1'b1;
                    hold_cnt_d       = HOLD_LOAD;
                    change_pending_d = 1'b0;
                end else begin
                    change_pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset to the resting mood.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            energy_q         <= 2'd2;
            stress_q         <= 2'd0;
            pleasure_q       <= 2'd2;
            emotion_out_q    <= 8'h00;
            emotion_update_q <= 1'b0;
            presc_q          <= '0;
            decay_pending_q  <= 1'b0;
            hold_cnt_q       <= '0;
            change_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            energy_q         <= energy_d;
            stress_q         <= stress_d;
            pleasure_q       <= pleasure_d;
            emotion_out_q    <= emotion_out_d;
            emotion_update_q <= emotion_update_d;
            presc_q          <= presc_d;
            decay_pending_q  <= decay_pending_d;
            hold_cnt_q       <= hold_cnt_d;
            change_pending_q <= change_pending_d;
        end
    end

endmodule

// File: tb/tb_emotion_sequencer.sv
// tb_emotion_sequencer: directed checks of levels, decay ticks, hold, collision and mid-sequence reset.
// Latency: all observations taken 1 time unit after a rising edge, counted from reset release.
// Backpressure: stimuli are held until stim_ready, bounded by a cycle budget.
module tb_emotion_sequencer;

    localparam logic [1:0] FEED  = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] SCOLD = 2'd2;

    logic       clk;
    logic       rst;
    logic       stim_valid;
    logic [1:0] stim_code;
    logic       stim_ready;
    logic [1:0] energy;
    logic [1:0] stress;
    logic [1:0] pleasure;
    logic [7:0] emotion_in;
    logic [7:0] emotion_out;
    logic       emotion_update;
    logic       busy;

    int n_checks;
    int n_errors;
    int upd_cnt;
    int upd_base;

    emotion_sequencer #(
        .TICK_DIV   (8),
        .HOLD_TICKS (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stim_valid     (stim_valid),
        .stim_code      (stim_code),
        .stim_ready     (stim_ready),
        .energy         (energy),
        .stress         (stress),
        .pleasure       (pleasure),
        .emotion_in     (emotion_in),
        .emotion_out    (emotion_out),
        .emotion_update (emotion_update),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every emotion_update pulse, sampled mid-cycle.
    initial upd_cnt = 0;
    always @(negedge clk) begin
        if (emotion_update === 1'b1) upd_cnt = upd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 unit after the edge on which rst fell; next edge is edge 1.
    task automatic do_reset();
        rst        = 1'b1;
        stim_valid = 1'b0;
        stim_code  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_stim(input logic [1:0] code, input string tag);
        bit acc;
        acc        = 1'b0;
        stim_code  = code;
        stim_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            if (stim_ready) acc = 1'b1;
            step(1);
        end
        stim_valid = 1'b0;
        chk(tag, 8'(acc), 8'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        stim_valid = 1'b0;
        stim_code  = 2'd0;
        emotion_in = 8'h00;

        // Reset state and pure decay sequence (no stimulus, classifier steady at 0x00).
        do_reset();
        upd_base = upd_cnt;
        chk("rst_e", 8'(energy), 8'd2);
        chk("rst_s", 8'(stress), 8'd0);
        chk("rst_p", 8'(pleasure), 8'd2);
        chk("rst_emo", emotion_out, 8'h00);
        chk("rst_rdy", 8'(stim_ready), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        step(8);
        chk("dec_e_e8", 8'(energy), 8'd2);
        chk("dec_rdy_e8", 8'(stim_ready), 8'd0);
        step(1);
        chk("dec_e_e9", 8'(energy), 8'd1);
        step(8);
        chk("dec_e_e17", 8'(energy), 8'd0);
        chk("dec_s_e17", 8'(stress), 8'd0);
        step(8);
        chk("dec_e_e25", 8'(energy), 8'd0);
        chk("dec_s_e25", 8'(stress), 8'd1);
        step(8);
        chk("dec_s_e33", 8'(stress), 8'd2);
        chk("dec_p_e33", 8'(pleasure), 8'd2);
        chk("dec_no_upd", 8'(upd_cnt - upd_base), 8'd0);

        // FEED from reset, then saturation under repeated FEEDs.
        emotion_in = 8'h11;
        do_reset();
        upd_base = upd_cnt;
        send_stim(FEED, "feed_acc");
        chk("feed_e", 8'(energy), 8'd3);
        chk("feed_s", 8'(stress), 8'd0);
        chk("feed_p", 8'(pleasure), 8'd3);
        chk("feed_busy", 8'(busy), 8'd1);
        chk("feed_rdy", 8'(stim_ready), 8'd0);
        step(1);
        chk("feed_emo_e2", emotion_out, 8'h00);
        step(1);
        chk("feed_emo_e3", emotion_out, 8'h11);
        chk("feed_upd_e3", 8'(emotion_update), 8'd1);
        step(1);
        chk("feed_upd_e4", 8'(emotion_update), 8'd0);
        for (int k = 0; k < 3; k++) begin
            send_stim(FEED, "sat_acc");
            chk("sat_e", 8'(energy), 8'd3);
            chk("sat_p", 8'(pleasure), 8'd3);
        end
        step(3);
        chk("feed_one_upd", 8'(upd_cnt - upd_base), 8'd1);

        // Hold: change during hold is deferred until hold expires, then committed once.
        emotion_in = 8'h11;
        do_reset();
        send_stim(FEED, "hold_feed_acc");
        step(2);
        chk("hold_emo_e3", emotion_out, 8'h11);
        emotion_in = 8'h22;
        send_stim(SCOLD, "hold_scold_acc");
        chk("hold_e", 8'(energy), 8'd3);
        chk("hold_s", 8'(stress), 8'd1);
        chk("hold_p", 8'(pleasure), 8'd2);
        step(2);
        chk("hold_emo_e6", emotion_out, 8'h11);
        chk("hold_rdy_e6", 8'(stim_ready), 8'd1);
        upd_base = upd_cnt;
        step(20);
        chk("hold_emo_e26", emotion_out, 8'h11);
        step(1);
        chk("hold_emo_e27", emotion_out, 8'h22);
        chk("hold_upd_e27", 8'(emotion_update), 8'd1);
        chk("hold_e_e27", 8'(energy), 8'd0);
        step(3);
        chk("hold_one_upd", 8'(upd_cnt - upd_base), 8'd1);

        // Collision: PLAY offered on the cycle a decay becomes pending.
        emotion_in = 8'h00;
        do_reset();
        step(8);
        stim_code  = PLAY;
        stim_valid = 1'b1;
        chk("col_rdy_c0", 8'(stim_ready), 8'd0);
        chk("col_e_c0", 8'(energy), 8'd2);
        step(1);
        chk("col_rdy_c1", 8'(stim_ready), 8'd0);
        chk("col_e_c1", 8'(energy), 8'd1);
        step(1);
        chk("col_rdy_c2", 8'(stim_ready), 8'd0);
        step(1);
        chk("col_rdy_c3", 8'(stim_ready), 8'd1);
        step(1);
        stim_valid = 1'b0;
        chk("col_e_fin", 8'(energy), 8'd0);
        chk("col_s_fin", 8'(stress), 8'd0);
        chk("col_p_fin", 8'(pleasure), 8'd3);

        // Reset during SETTLE aborts without a pulse; operation resumes afterwards.
        emotion_in = 8'h33;
        do_reset();
        send_stim(SCOLD, "ar_scold_acc");
        chk("ar_s_pre", 8'(stress), 8'd1);
        chk("ar_busy_pre", 8'(busy), 8'd1);
        upd_base = upd_cnt;
        rst = 1'b1;
        #1;
        chk("ar_e", 8'(energy), 8'd2);
        chk("ar_s", 8'(stress), 8'd0);
        chk("ar_p", 8'(pleasure), 8'd2);
        chk("ar_busy", 8'(busy), 8'd0);
        step(2);
        rst = 1'b0;
        step(3);
        chk("ar_no_upd", 8'(upd_cnt - upd_base), 8'd0);
        chk("ar_emo", emotion_out, 8'h00);
        send_stim(SCOLD, "ar_resume_acc");
        step(2);
        chk("ar_resume_emo", emotion_out, 8'h33);
        chk("ar_resume_upd", 8'(emotion_update), 8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
